// File: rtl/mc_muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// func3 encodings, control states and operand-signedness helpers.
package mdu_pkg;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_CALC = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Upper func3 bit separates the divide group from the multiply group.
   function automatic logic is_div(input logic [2:0] f3);
      return f3[2];
   endfunction

   // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
   function automatic logic is_signed_a(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   // rs2 is treated as signed for MULH, DIV and REM.
   function automatic logic is_signed_b(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/mc_muldiv_unit_if.sv
// Operand/result bus between the core control path and the multiply/divide unit.
//
// Handshake: the unit is ready exactly when busy is low. A start seen while busy
// is low launches one operation and latches func3/src_a/src_b in that cycle; the
// operation ends with a single-cycle done pulse (result valid in that cycle and
// held afterwards), or silently when kill is raised before the done cycle.
interface mc_muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      func3;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic            kill;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, func3, src_a, src_b, kill,
      input  busy, done, result
   );

   modport slave (
      input  start, func3, src_a, src_b, kill,
      output busy, done, result
   );
endinterface

// File: rtl/mc_muldiv_unit_step.sv
// One radix-2 iteration of the shared accumulator.
// mode=0: shift-add multiply; acc = {partial product high, multiplier/low product}.
// mode=1: restoring divide; acc = {partial remainder, dividend/quotient bits}.
module mdu_step #(
   parameter int XLEN = 32
) (
   input  logic              mode,
   input  logic [2*XLEN-1:0] acc_in,
   input  logic [XLEN-1:0]   opnd,
   output logic [2*XLEN-1:0] acc_out
);
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [XLEN:0]   sum;
   logic [XLEN:0]   rsh;
   logic [XLEN:0]   diff;

   // Single iteration: add-and-shift-right for multiply, shift-left-and-trial-subtract for divide.
   always_comb begin
      hi   = acc_in[2*XLEN-1:XLEN];
      lo   = acc_in[XLEN-1:0];
      sum  = {1'b0, hi} + {1'b0, opnd};
      // Shifted remainder needs one extra bit: it can reach 2*divisor-1.
      rsh  = {hi, lo[XLEN-1]};
      diff = rsh - {1'b0, opnd};
      acc_out = acc_in;
      if (mode) begin
         if (!diff[XLEN]) begin
            acc_out = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
         end else begin
            acc_out = {rsh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
         end
      end else begin
         if (lo[0]) begin
            acc_out = {sum, lo[XLEN-1:1]};
         end else begin
            acc_out = {1'b0, hi, lo[XLEN-1:1]};
         end
      end
   end
endmodule

// File: rtl/mc_muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes in
// PREP, iterated UNROLL radix-2 steps per clock in CALC, sign-corrected in FIX
// and published on entry to DONE. Divide-by-zero and signed overflow bypass CALC.
module mc_muldiv_unit
   import mdu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            rst,
   mc_muldiv_unit_if.slave bus,
   output state_t          dbg_state
);
   localparam int N  = XLEN / UNROLL;
   localparam int CW = $clog2(N + 1);

   if ((XLEN % 2) != 0 || XLEN < 8) begin : g_bad_xlen
      $error("mc_muldiv_unit: XLEN must be even and >= 8");
   end
   if ((XLEN % UNROLL) != 0) begin : g_bad_unroll
      $error("mc_muldiv_unit: XLEN must be a multiple of UNROLL");
   end

   state_t            state;
   state_t            state_nx;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   opnd;
   logic [XLEN-1:0]   result_q;
   logic [2:0]        op;
   logic              neg_q;
   logic              neg_r;

   logic              div_mode;
   logic [XLEN-1:0]   b_raw;
   logic              sa;
   logic              sb;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic              div_zero;
   logic              div_ovf;
   logic              fast;
   logic [XLEN-1:0]   fast_res;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   fix_res;

   logic [2*XLEN-1:0] chain [UNROLL+1];

   assign bus.busy   = (state != S_IDLE);
   assign bus.done   = (state == S_DONE);
   assign bus.result = result_q;
   assign dbg_state  = state;

   assign div_mode = is_div(op);

   // UNROLL iterations chained combinationally; the register captures the last link.
   assign chain[0] = acc;
   for (genvar g = 0; g < UNROLL; g++) begin : g_step
      mdu_step #(.XLEN(XLEN)) u_step (
         .mode   (div_mode),
         .acc_in (chain[g]),
         .opnd   (opnd),
         .acc_out(chain[g+1])
      );
   end

   // Operand preparation: raw src_b sits in the low half of acc until PREP rewrites it.
   always_comb begin
      b_raw    = acc[XLEN-1:0];
      sa       = is_signed_a(op) & opnd[XLEN-1];
      sb       = is_signed_b(op) & b_raw[XLEN-1];
      mag_a    = sa ? (~opnd + 1'b1) : opnd;
      mag_b    = sb ? (~b_raw + 1'b1) : b_raw;
      div_zero = (b_raw == '0);
      div_ovf  = ((op == F3_DIV) || (op == F3_REM)) &&
                 (opnd == {1'b1, {(XLEN-1){1'b0}}}) && (b_raw == '1);
      fast     = div_mode && (div_zero || div_ovf);
      fast_res = '0;
      if (div_zero) begin
         fast_res = op[1] ? opnd : '1;
      end else if (div_ovf) begin
         fast_res = op[1] ? '0 : opnd;
      end
   end

   // Sign correction: negate the full product/quotient; the remainder follows the dividend.
   always_comb begin
      prod_fix = neg_q ? (~acc + 1'b1) : acc;
      quo      = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
      rem      = neg_r ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
      fix_res  = '0;
      if (div_mode) begin
         fix_res = op[1] ? rem : quo;
      end else if (op == F3_MUL) begin
         fix_res = prod_fix[XLEN-1:0];
      end else begin
         fix_res = prod_fix[2*XLEN-1:XLEN];
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic: kill aborts only before DONE; start is only looked at in IDLE.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (bus.start) state_nx = S_PREP;
         S_PREP: begin
            if (bus.kill)  state_nx = S_IDLE;
            else if (fast) state_nx = S_DONE;
            else           state_nx = S_CALC;
         end
         S_CALC: begin
            if (bus.kill)        state_nx = S_IDLE;
            else if (cnt == '0)  state_nx = S_FIX;
         end
         S_FIX: begin
            if (bus.kill) state_nx = S_IDLE;
            else          state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath registers: latch on start, prepare, iterate, and commit the result into DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         result_q <= '0;
         op       <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  op   <= bus.func3;
                  opnd <= bus.src_a;
                  acc  <= {{XLEN{1'b0}}, bus.src_b};
               end
            end
            S_PREP: begin
               neg_q <= sa ^ sb;
               neg_r <= sa;
               cnt   <= CW'(N - 1);
               if (div_mode) begin
                  acc  <= {{XLEN{1'b0}}, mag_a};
                  opnd <= mag_b;
               end else begin
                  acc  <= {{XLEN{1'b0}}, mag_b};
                  opnd <= mag_a;
               end
               if (!bus.kill && fast) result_q <= fast_res;
            end
            S_CALC: begin
               acc <= chain[UNROLL];
               if (cnt != '0) cnt <= cnt - CW'(1);
            end
            S_FIX: begin
               if (!bus.kill) result_q <= fix_res;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mc_muldiv_unit.sv
// Self-checking bench for mc_muldiv_unit: one instance with UNROLL=1 and one
// with UNROLL=4, directed cases, abort/reset scenarios and random operations
// checked against a plain-arithmetic model of the RV32M rules.
module tb_mc_muldiv_unit;
  import mdu_pkg::*;

  logic clk;
  logic rst;
  state_t st1;
  state_t st4;
  int n_pass;
  int n_total;
  logic [31:0] last1;
  logic [31:0] last4;

  mc_muldiv_unit_if #(.XLEN(32)) bus1 ();
  mc_muldiv_unit_if #(.XLEN(32)) bus4 ();

  mc_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(st1)
  );
  mc_muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .dbg_state(st4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p = '0;
    case (f3)
      F3_MUL:    begin p = ua * ub; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub; return p[63:32]; end
      F3_MULHU:  begin p = ua * ub; return p[63:32]; end
      F3_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      F3_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      F3_REM: begin
        if (b == 32'd0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_cycles(input bit u4, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit fastp;
    fastp = f3[2] && ((b == 32'd0) ||
            (((f3 == F3_DIV) || (f3 == F3_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    if (fastp) return 2;
    return u4 ? (32 / 4 + 3) : (32 + 3);
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // driver tasks
  task automatic drive(input bit u4, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic kl);
    if (u4) begin
      bus4.start = st; bus4.func3 = f3; bus4.src_a = a; bus4.src_b = b; bus4.kill = kl;
    end else begin
      bus1.start = st; bus1.func3 = f3; bus1.src_a = a; bus1.src_b = b; bus1.kill = kl;
    end
  endtask

  task automatic sample(input bit u4, output logic bsy, output logic dn, output logic [31:0] r, output state_t s);
    if (u4) begin
      bsy = bus4.busy; dn = bus4.done; r = bus4.result; s = st4;
    end else begin
      bsy = bus1.busy; dn = bus1.done; r = bus1.result; s = st1;
    end
  endtask

  // Launch in the current cycle (cycle 0), scramble inputs from cycle 1, wait for done (bounded).
  task automatic run_op(input bit u4, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int dcyc, output int busy_bad, output logic busy_after);
    logic bsy;
    logic dn;
    logic [31:0] r;
    state_t s;
    drive(u4, 1'b1, f3, a, b, 1'b0);
    dcyc = -1;
    busy_bad = 0;
    res = 'x;
    for (int c = 1; c <= 60 && dcyc < 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) drive(u4, 1'b0, 3'($urandom), $urandom, $urandom, 1'b0);
      sample(u4, bsy, dn, r, s);
      if (bsy !== 1'b1) busy_bad++;
      if (dn === 1'b1) begin
        dcyc = c;
        res = r;
      end
    end
    @(posedge clk); #1;
    sample(u4, bsy, dn, r, s);
    busy_after = bsy;
  endtask

  // scoreboarded single op: compare result, latency, busy window
  task automatic check_op(input bit u4, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
    logic [31:0] res;
    logic [31:0] exp_q[$];
    int dcyc;
    int bb;
    logic ba;
    int exp_c;
    exp_q.push_back(ref_op(f3, a, b));
    exp_c = ref_cycles(u4, f3, a, b);
    run_op(u4, f3, a, b, res, dcyc, bb, ba);
    n_total++;
    if (res !== exp_q[0])
      $display("FAIL %s result f3=%0d a=%h b=%h: got %h want %h", tag, f3, a, b, res, exp_q[0]);
    else n_pass++;
    n_total++;
    if (dcyc !== exp_c)
      $display("FAIL %s done_cycle f3=%0d a=%h b=%h: got %0d want %0d", tag, f3, a, b, dcyc, exp_c);
    else n_pass++;
    n_total++;
    if (bb !== 0 || ba !== 1'b0)
      $display("FAIL %s busy_window: low_cycles=%0d busy_after=%b want 0/0", tag, bb, ba);
    else n_pass++;
    if (u4) last4 = exp_q[0]; else last1 = exp_q[0];
  endtask

  task automatic test_reset();
    logic bsy;
    logic dn;
    logic [31:0] r;
    state_t s;
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      sample(u[0], bsy, dn, r, s);
      n_total++;
      if (bsy !== 1'b0 || dn !== 1'b0) $display("FAIL reset_flags u%0d: busy=%b done=%b want 0/0", u, bsy, dn);
      else n_pass++;
      n_total++;
      if (r !== 32'd0) $display("FAIL reset_result u%0d: got %h want 0", u, r);
      else n_pass++;
      n_total++;
      if (s !== S_IDLE) $display("FAIL reset_state u%0d: got %0d want %0d", u, s, S_IDLE);
      else n_pass++;
    end
    #2 rst = 1'b1;
    last1 = '0;
    last4 = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [2:0]  f3_t [14];
    logic [31:0] a_t  [14];
    logic [31:0] b_t  [14];
    logic [31:0] e_t  [14];
    f3_t = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU, F3_DIV, F3_REM, F3_DIVU, F3_REMU,
             F3_DIVU, F3_REMU, F3_DIV, F3_REM, F3_DIV, F3_REM};
    a_t  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
             32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFF9};
    b_t  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    e_t  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
             32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    for (int i = 0; i < 14; i++) begin
      n_total++;
      if (ref_op(f3_t[i], a_t[i], b_t[i]) !== e_t[i])
        $display("FAIL model_vector %0d: got %h want %h", i, ref_op(f3_t[i], a_t[i], b_t[i]), e_t[i]);
      else n_pass++;
      check_op(1'b0, f3_t[i], a_t[i], b_t[i], "directed_u1");
      check_op(1'b1, f3_t[i], a_t[i], b_t[i], "directed_u4");
    end
  endtask

  task automatic test_kill();
    logic bsy;
    logic dn;
    logic [31:0] r;
    state_t s;
    int seen_done;
    drive(1'b0, 1'b1, F3_DIV, 32'd1000, 32'd3, 1'b0);
    seen_done = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (c == 1) drive(1'b0, 1'b0, F3_DIV, 32'd1000, 32'd3, 1'b0);
      if (c == 11) drive(1'b0, 1'b0, F3_DIV, 32'd1000, 32'd3, 1'b0);
      sample(1'b0, bsy, dn, r, s);
      if (dn === 1'b1) seen_done++;
      if (c == 10) begin
        n_total++;
        if (bsy !== 1'b1) $display("FAIL kill_busy_before: got %b want 1", bsy);
        else n_pass++;
        drive(1'b0, 1'b0, F3_DIV, 32'd1000, 32'd3, 1'b1);
      end
      if (c == 11) begin
        n_total++;
        if (bsy !== 1'b0 || s !== S_IDLE) $display("FAIL kill_idle: busy=%b state=%0d want 0/%0d", bsy, s, S_IDLE);
        else n_pass++;
      end
    end
    n_total++;
    if (seen_done !== 0) $display("FAIL kill_no_done: got %0d pulses want 0", seen_done);
    else n_pass++;
    n_total++;
    if (r !== last1) $display("FAIL kill_result_held: got %h want %h", r, last1);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    logic bsy;
    logic dn;
    logic [31:0] r;
    state_t s;
    int dcyc;
    drive(1'b0, 1'b1, F3_MUL, 32'd3, 32'd5, 1'b0);
    dcyc = -1;
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk); #1;
      if (c == 1) drive(1'b0, 1'b0, F3_MUL, 32'd3, 32'd5, 1'b0);
      if (c == 3) drive(1'b0, 1'b1, F3_DIVU, 32'd100, 32'd7, 1'b0);
      if (c == 20) drive(1'b0, 1'b0, F3_DIVU, 32'd100, 32'd7, 1'b0);
      sample(1'b0, bsy, dn, r, s);
      if (dn === 1'b1 && dcyc < 0) begin
        dcyc = c;
        n_total++;
        if (r !== 32'd15) $display("FAIL ignored_start_result: got %h want %h", r, 32'd15);
        else n_pass++;
      end
      if (c == 36) begin
        n_total++;
        if (bsy !== 1'b0) $display("FAIL ignored_start_idle: busy=%b want 0", bsy);
        else n_pass++;
      end
    end
    n_total++;
    if (dcyc !== 35) $display("FAIL ignored_start_cycle: got %0d want 35", dcyc);
    else n_pass++;
    last1 = 32'd15;
  endtask

  task automatic test_kill_edges();
    logic bsy;
    logic dn;
    logic [31:0] r;
    state_t s;
    int dcyc;
    // start and kill together in IDLE: start wins
    drive(1'b1, 1'b1, F3_MULHU, 32'hFFFF_FFFF, 32'h0000_0010, 1'b1);
    dcyc = -1;
    for (int c = 1; c <= 30 && dcyc < 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) drive(1'b1, 1'b0, F3_MUL, 32'd0, 32'd0, 1'b0);
      sample(1'b1, bsy, dn, r, s);
      if (c == 1) begin
        n_total++;
        if (bsy !== 1'b1) $display("FAIL start_beats_kill: busy=%b want 1", bsy);
        else n_pass++;
      end
      if (dn === 1'b1) begin
        dcyc = c;
        drive(1'b1, 1'b0, F3_MUL, 32'd0, 32'd0, 1'b1);
      end
    end
    n_total++;
    if (dcyc !== 11) $display("FAIL start_kill_cycle: got %0d want 11", dcyc);
    else n_pass++;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, F3_MUL, 32'd0, 32'd0, 1'b0);
    sample(1'b1, bsy, dn, r, s);
    n_total++;
    if (bsy !== 1'b0 || r !== 32'h0000_000F)
      $display("FAIL kill_in_done: busy=%b result=%h want 0/%h", bsy, r, 32'h0000_000F);
    else n_pass++;
    last4 = 32'h0000_000F;
  endtask

  task automatic test_async_reset();
    logic bsy;
    logic dn;
    logic [31:0] r;
    state_t s;
    drive(1'b0, 1'b1, F3_DIV, 32'd1000, 32'd3, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      if (c == 1) drive(1'b0, 1'b0, F3_DIV, 32'd1000, 32'd3, 1'b0);
    end
    sample(1'b0, bsy, dn, r, s);
    n_total++;
    if (bsy !== 1'b1 || r !== last1) $display("FAIL pre_reset: busy=%b result=%h want 1/%h", bsy, r, last1);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    sample(1'b0, bsy, dn, r, s);
    n_total++;
    if (bsy !== 1'b0 || dn !== 1'b0 || r !== 32'd0 || s !== S_IDLE)
      $display("FAIL async_reset: busy=%b done=%b result=%h state=%0d want 0/0/0/0", bsy, dn, r, s);
    else n_pass++;
    #1 rst = 1'b1;
    last1 = '0;
    last4 = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_random(input bit u4, input int n_ops);
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < n_ops; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = rand_operand();
      b = rand_operand();
      check_op(u4, f3, a, b, u4 ? "random_u4" : "random_u1");
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_directed();
    test_kill();
    test_start_ignored();
    test_kill_edges();
    test_async_reset();
    test_random(1'b1, 2000);
    test_random(1'b0, 150);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
